// File: rtl/mem_io_bridge_pkg.sv
// Shared address map, region codes and read-source select for the CPU memory/IO bridge.
package mem_io_bridge_pkg;

   localparam logic [17:0] IO_BASE    = 18'h30000;
   localparam logic [2:0]  IO_DAT_OFF = 3'h0;
   localparam logic [2:0]  IO_CNT_OFF = 3'h4;

   typedef enum logic [1:0] {
      RGN_RAM_LO = 2'b00,
      RGN_RAM_HI = 2'b01,
      RGN_HOLE   = 2'b10,
      RGN_IO     = IO_BASE[17:16]
   } region_e;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_RXB  = 2'd2,
      SRC_CNT  = 2'd3
   } rd_src_e;

   function automatic region_e region_of(input logic [31:0] addr);
      return region_e'(addr[17:16]);
   endfunction

endpackage

// File: rtl/mem_io_bridge_tx_fifo.sv
// Synchronous FIFO for UART TX bytes, with a registered near-full flag and sticky overflow.
module io_tx_fifo
   import mem_io_bridge_pkg::*;
#(
   parameter int DEPTH_LOG   = 3,
   parameter int DATA_W      = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_dat,
   input  logic              pop,
   output logic              valid,
   output logic [DATA_W-1:0] head,
   output logic              near_full,
   output logic              ovf
);

   localparam int DEPTH = 1 << DEPTH_LOG;

   logic [DEPTH_LOG:0]  wptr, rptr, count, count_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                empty, full, do_push, do_pop;

   assign count   = wptr - rptr;
   assign empty   = (count == '0);
   assign full    = (count == (DEPTH_LOG+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is still accepted when the head leaves on the same edge.
   assign do_push = push & (~full | do_pop);
   assign count_nxt = count + (DEPTH_LOG+1)'(do_push) - (DEPTH_LOG+1)'(do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         near_full <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         near_full <= (count_nxt >= (DEPTH_LOG+1)'(DEPTH - FULL_MARGIN));
         if (push & ~do_push) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[DEPTH_LOG-1:0]] <= push_dat;
   end

   assign valid = ~empty;
   assign head  = empty ? '0 : mem[rptr[DEPTH_LOG-1:0]];

endmodule

// File: rtl/mem_io_bridge.sv
// Splits the CPU byte bus between RAM and memory-mapped IO (UART TX/RX, cycle counter, stop).
module mem_io_bridge
   import mem_io_bridge_pkg::*;
#(
   parameter int TX_DEPTH_LOG = 3,
   parameter int FULL_MARGIN  = 2,
   parameter int CNT_W        = 32
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] cpu_a_i,
   input  logic [7:0]  cpu_dat_i,
   input  logic        cpu_wr_i,
   output logic [7:0]  cpu_dat_o,
   output logic        io_buffer_full,
   output logic [16:0] ram_a_o,
   output logic        ram_we_o,
   output logic [7:0]  ram_dat_o,
   input  logic [7:0]  ram_dat_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_dat_i,
   output logic        rx_pop_o,
   output logic        tx_valid_o,
   output logic [7:0]  tx_dat_o,
   input  logic        tx_ready_i,
   output logic        stop_o,
   output logic        ovf_o
);

   logic [CNT_W-1:0] cnt;
   logic [31:0]      snap;
   logic [2:0]       sub;
   logic             tx_push, stop_set, snap_ld;
   logic [7:0]       tx_push_dat;
   rd_src_e          nxt_src, rd_src_p1;
   logic [7:0]       nxt_byte, rd_byte_p1;
   logic             unused_addr;

   assign sub         = cpu_a_i[2:0];
   assign ram_a_o     = cpu_a_i[16:0];
   assign ram_dat_o   = cpu_dat_i;
   assign unused_addr = ^cpu_a_i[31:18];

   always_comb begin
      ram_we_o    = 1'b0;
      rx_pop_o    = 1'b0;
      tx_push     = 1'b0;
      tx_push_dat = cpu_dat_i;
      stop_set    = 1'b0;
      snap_ld     = 1'b0;
      nxt_src     = SRC_NONE;
      nxt_byte    = 8'h00;
      if (rdy_in) begin
         case (region_of(cpu_a_i))
            RGN_RAM_LO, RGN_RAM_HI: begin
               ram_we_o = cpu_wr_i;
               if (!cpu_wr_i) nxt_src = SRC_RAM;
            end
            RGN_IO: begin
               if (cpu_wr_i) begin
                  if (sub == IO_DAT_OFF) begin
                     tx_push = (cpu_dat_i != 8'h00);
                  end else if (sub == IO_CNT_OFF) begin
                     tx_push     = 1'b1;
                     tx_push_dat = 8'h00;
                     stop_set    = 1'b1;
                  end
               end else if (sub == IO_DAT_OFF) begin
                  if (rx_valid_i) begin
                     rx_pop_o = 1'b1;
                     nxt_src  = SRC_RXB;
                     nxt_byte = rx_dat_i;
                  end
               end else if (sub[2] == IO_CNT_OFF[2]) begin
                  // Byte 0 samples the live counter and freezes the rest for bytes 1..3.
                  nxt_src = SRC_CNT;
                  if (sub[1:0] == 2'd0) begin
                     nxt_byte = cnt[7:0];
                     snap_ld  = 1'b1;
                  end else begin
                     nxt_byte = snap[{sub[1:0], 3'b000} +: 8];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Read-return stage: one cycle after the request.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt        <= '0;
         snap       <= '0;
         rd_src_p1  <= SRC_NONE;
         rd_byte_p1 <= 8'h00;
         stop_o     <= 1'b0;
      end else if (rdy_in) begin
         cnt        <= cnt + CNT_W'(1);
         rd_src_p1  <= nxt_src;
         rd_byte_p1 <= nxt_byte;
         if (snap_ld)  snap   <= cnt[31:0];
         if (stop_set) stop_o <= 1'b1;
      end
   end

   assign cpu_dat_o = (rd_src_p1 == SRC_RAM) ? ram_dat_i : rd_byte_p1;

   io_tx_fifo #(
      .DEPTH_LOG   (TX_DEPTH_LOG),
      .DATA_W      (8),
      .FULL_MARGIN (FULL_MARGIN)
   ) u_tx_fifo (
      .clk       (clk_in),
      .rst       (rst_in),
      .push      (tx_push),
      .push_dat  (tx_push_dat),
      .pop       (tx_valid_o & tx_ready_i),
      .valid     (tx_valid_o),
      .head      (tx_dat_o),
      .near_full (io_buffer_full),
      .ovf       (ovf_o)
   );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a small synchronous RAM model on the RAM port.
module tb_mem_io_bridge;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] cpu_a_i;
   logic [7:0]  cpu_dat_i;
   logic        cpu_wr_i;
   logic [7:0]  cpu_dat_o;
   logic        io_buffer_full;
   logic [16:0] ram_a_o;
   logic        ram_we_o;
   logic [7:0]  ram_dat_o;
   logic [7:0]  ram_dat_i;
   logic        rx_valid_i;
   logic [7:0]  rx_dat_i;
   logic        rx_pop_o;
   logic        tx_valid_o;
   logic [7:0]  tx_dat_o;
   logic        tx_ready_i;
   logic        stop_o;
   logic        ovf_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] tb_ram [0:131071];

   mem_io_bridge dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .cpu_a_i        (cpu_a_i),
      .cpu_dat_i      (cpu_dat_i),
      .cpu_wr_i       (cpu_wr_i),
      .cpu_dat_o      (cpu_dat_o),
      .io_buffer_full (io_buffer_full),
      .ram_a_o        (ram_a_o),
      .ram_we_o       (ram_we_o),
      .ram_dat_o      (ram_dat_o),
      .ram_dat_i      (ram_dat_i),
      .rx_valid_i     (rx_valid_i),
      .rx_dat_i       (rx_dat_i),
      .rx_pop_o       (rx_pop_o),
      .tx_valid_o     (tx_valid_o),
      .tx_dat_o       (tx_dat_o),
      .tx_ready_i     (tx_ready_i),
      .stop_o         (stop_o),
      .ovf_o          (ovf_o)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      if (ram_we_o) tb_ram[ram_a_o] <= ram_dat_o;
      ram_dat_i <= tb_ram[ram_a_o];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   task automatic drv(input logic wr, input logic [31:0] a, input logic [7:0] d);
      cpu_wr_i  = wr;
      cpu_a_i   = a;
      cpu_dat_i = d;
   endtask

   task automatic idle;
      drv(1'b0, 32'h0002_0000, 8'h00);
   endtask

   initial begin
      logic [7:0] bp_exp [8];
      bp_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};

      rst_in     = 1'b1;
      rdy_in     = 1'b1;
      rx_valid_i = 1'b0;
      rx_dat_i   = 8'h00;
      tx_ready_i = 1'b0;
      idle();
      tick();
      tick();
      chk("rst_cpu_dat", cpu_dat_o, 8'h00);
      chk("rst_tx_valid", tx_valid_o, 1'b0);
      chk("rst_tx_dat", tx_dat_o, 8'h00);
      chk("rst_full", io_buffer_full, 1'b0);
      chk("rst_stop", stop_o, 1'b0);
      chk("rst_ovf", ovf_o, 1'b0);
      rst_in = 1'b0;

      // counter reaches 0xFF after 255 running cycles
      repeat (255) tick();
      drv(1'b0, 32'h0003_0004, 8'h00); tick(); chk("cnt_b0", cpu_dat_o, 8'hFF);
      drv(1'b0, 32'h0003_0005, 8'h00); tick(); chk("cnt_b1", cpu_dat_o, 8'h00);
      drv(1'b0, 32'h0003_0006, 8'h00); tick(); chk("cnt_b2", cpu_dat_o, 8'h00);
      drv(1'b0, 32'h0003_0007, 8'h00); tick(); chk("cnt_b3", cpu_dat_o, 8'h00);
      drv(1'b0, 32'h0003_0004, 8'h00); tick(); chk("cnt_b0_again", cpu_dat_o, 8'h03);

      rdy_in = 1'b0;
      drv(1'b1, 32'h0000_0456, 8'h99);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_we", ram_we_o, 1'b0);
         chk("stall_hold", cpu_dat_o, 8'h03);
         tick();
      end
      rdy_in = 1'b1;
      drv(1'b0, 32'h0003_0004, 8'h00); tick(); chk("cnt_after_stall", cpu_dat_o, 8'h04);

      drv(1'b1, 32'h0000_0123, 8'hA5);
      #1;
      chk("ram_we", ram_we_o, 1'b1);
      chk("ram_a", ram_a_o, 17'h00123);
      chk("ram_wdat", ram_dat_o, 8'hA5);
      tick();
      drv(1'b0, 32'h0000_0123, 8'h00); tick(); chk("ram_rd", cpu_dat_o, 8'hA5);
      drv(1'b1, 32'h0002_0123, 8'h77);
      #1;
      chk("hole_we", ram_we_o, 1'b0);
      tick();
      drv(1'b0, 32'h0002_0123, 8'h00); tick(); chk("hole_rd", cpu_dat_o, 8'h00);
      drv(1'b0, 32'h0000_0123, 8'h00); tick(); chk("ram_rd_kept", cpu_dat_o, 8'hA5);

      tx_ready_i = 1'b0;
      drv(1'b1, 32'h0003_0000, 8'h48); tick();
      drv(1'b1, 32'h0003_0000, 8'h00); tick();
      drv(1'b1, 32'h0003_0000, 8'h69); tick();
      idle();
      chk("uart_valid", tx_valid_o, 1'b1);
      chk("uart_h", tx_dat_o, 8'h48);
      tx_ready_i = 1'b1;
      tick(); chk("uart_i", tx_dat_o, 8'h69);
      tick(); chk("uart_empty", tx_valid_o, 1'b0);

      drv(1'b1, 32'h0003_0000, 8'h55);
      #1;
      chk("no_bypass", tx_valid_o, 1'b0);
      tick();
      idle();
      chk("push_empty_valid", tx_valid_o, 1'b1);
      chk("push_empty_dat", tx_dat_o, 8'h55);
      tick(); chk("push_empty_drained", tx_valid_o, 1'b0);
      tx_ready_i = 1'b0;

      for (int i = 1; i <= 6; i++) begin
         drv(1'b1, 32'h0003_0000, 8'(i));
         tick();
         if (i == 5) chk("bp_full_at5", io_buffer_full, 1'b0);
      end
      chk("bp_full_at6", io_buffer_full, 1'b1);
      drv(1'b1, 32'h0003_0000, 8'h07); tick();
      drv(1'b1, 32'h0003_0000, 8'h08); tick();
      chk("bp_no_ovf", ovf_o, 1'b0);
      drv(1'b1, 32'h0003_0000, 8'h09); tick();
      chk("bp_ovf", ovf_o, 1'b1);
      tx_ready_i = 1'b1;
      drv(1'b1, 32'h0003_0000, 8'h0A); tick();
      idle();
      chk("bp_full_after_swap", io_buffer_full, 1'b1);
      for (int k = 0; k < 8; k++) begin
         chk("bp_drain", tx_dat_o, bp_exp[k]);
         tick();
      end
      chk("bp_drained_valid", tx_valid_o, 1'b0);
      chk("bp_drained_full", io_buffer_full, 1'b0);
      tx_ready_i = 1'b0;

      rx_valid_i = 1'b1;
      rx_dat_i   = 8'h31;
      drv(1'b0, 32'h0003_0000, 8'h00);
      #1;
      chk("rx_pop", rx_pop_o, 1'b1);
      tick();
      rx_valid_i = 1'b0;
      idle();
      chk("rx_dat", cpu_dat_o, 8'h31);
      drv(1'b0, 32'h0003_0000, 8'h00);
      #1;
      chk("rx_nopop", rx_pop_o, 1'b0);
      tick();
      chk("rx_empty_dat", cpu_dat_o, 8'h00);
      drv(1'b1, 32'h0003_0004, 8'h5A); tick();
      idle();
      chk("stop_set", stop_o, 1'b1);
      chk("stop_tx_valid", tx_valid_o, 1'b1);
      chk("stop_tx_zero", tx_dat_o, 8'h00);

      for (int i = 0; i < 6; i++) begin
         drv(1'b1, 32'h0003_0000, 8'(8'h40 + i));
         tick();
      end
      idle();
      tx_ready_i = 1'b1;
      tick();
      chk("pre_rst_full", io_buffer_full, 1'b1);
      chk("pre_rst_valid", tx_valid_o, 1'b1);
      chk("pre_rst_ovf", ovf_o, 1'b1);
      #2;
      rst_in = 1'b1;
      #1;
      chk("mid_rst_valid", tx_valid_o, 1'b0);
      chk("mid_rst_stop", stop_o, 1'b0);
      chk("mid_rst_ovf", ovf_o, 1'b0);
      chk("mid_rst_full", io_buffer_full, 1'b0);
      chk("mid_rst_cpu_dat", cpu_dat_o, 8'h00);
      tick();
      rst_in = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Sits directly downstream of the CPU core's byte-wide memory bus (address, data out, write flag, data in) and splits it between the 128 KB RAM and the memory-mapped I/O space.
- I/O space is any address with mem_a[17:16]==2'b11.
- Provides one-cycle read return, a UART TX buffer with back-pressure via io_buffer_full, UART RX pop, a cycles-since-start counter, and program-stop signalling.

Parameters:
- TX_DEPTH_LOG, 3, log2 of TX FIFO entries (8).
- FULL_MARGIN, 2, free entries still remaining when io_buffer_full asserts.
- CNT_W, 32, cycle counter width.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  CPU-side actions and counter advance only when high
- cpu_a_i  in  32  address from CPU (only 17:0 decoded)
- cpu_dat_i  in  8  write data from CPU
- cpu_wr_i  in  1  1 = write, 0 = read
- cpu_dat_o  out  8  read data to CPU, valid the cycle after the request
- io_buffer_full  out  1  TX FIFO near full; CPU must not issue an I/O write
- ram_a_o  out  17  RAM address
- ram_we_o  out  1  RAM write enable
- ram_dat_o  out  8  RAM write data
- ram_dat_i  in  8  RAM read data (synchronous, 1-cycle)
- rx_valid_i  in  1  UART RX byte available
- rx_dat_i  in  8  UART RX byte
- rx_pop_o  out  1  consume RX byte (combinational pulse)
- tx_valid_o  out  1  TX FIFO non-empty
- tx_dat_o  out  8  TX FIFO head byte
- tx_ready_i  in  1  UART accepts head byte
- stop_o  out  1  sticky program-stop flag
- ovf_o  out  1  sticky TX overflow flag (debug)

Behaviour:
Reset:
- All outputs 0; FIFO empty; counter 0; snapshot 0; source select = NONE.
- Reset may arrive mid-operation: in-flight read returns 0, FIFO contents discarded.

Decode (combinational on cpu_a_i, qualified by rdy_in):
- RAM: a[17:16]==00 or 01 -> ram_a_o = a[16:0], ram_dat_o = cpu_dat_i, ram_we_o = cpu_wr_i & rdy_in.
- Hole: a[17:16]==10 -> writes ignored, reads return 0.
- IO: a[17:16]==11, sub-address a[2:0] (upper bits ignored):
  - Write 0x30000: push cpu_dat_i into TX FIFO unless the byte is 0x00 (ignored).
  - Write 0x30004: push 0x00 into TX FIFO and set stop_o (sticky until reset); later writes re-push 0x00 only.
  - Read 0x30000: if rx_valid_i, pulse rx_pop_o and return rx_dat_i; else return 0, no pop.
  - Read 0x30004..0x30007: byte a[1:0] of the counter, little-endian. Reading 0x30004 returns live counter byte 0 and latches the full counter into the snapshot; 0x30005..7 return snapshot bytes so the dword is coherent.
  - Other IO addresses: writes ignored, reads return 0.

Read return:
- Registered source select {NONE, RAM, RXB, CNT} plus registered byte.
- Next cycle: cpu_dat_o = ram_dat_i if RAM, else the registered byte.
- Latency is exactly 1 cycle.
- When rdy_in is low, the select and registered byte hold and no new request is decoded.

Counter:
- Increments by 1 on every clk with rdy_in high; wraps at 2^CNT_W.

TX FIFO:
- Depth 2^TX_DEPTH_LOG; pointers have one extra wrap bit; count = wptr - rptr.
- Pop when tx_valid_o & tx_ready_i, independent of rdy_in.
- Push and pop in the same cycle is legal, including when full (count unchanged).
- Push when full and no simultaneous pop: byte dropped, ovf_o set (sticky).
- Push when empty with tx_ready_i high: byte does not bypass; it appears on tx_dat_o the next cycle.

io_buffer_full:
- Registered: high when count >= 2^TX_DEPTH_LOG - FULL_MARGIN after the current cycle's push/pop.
- Reset value 0.

Decomposition:
- Shared package: IO_BASE (0x30000), IO_DAT_OFF (0x0), IO_CNT_OFF (0x4), region codes, read-source enum {SRC_NONE, SRC_RAM, SRC_RXB, SRC_CNT}.
- One sub-module, io_tx_fifo: parameterised sync FIFO with push/pop/count, used here for TX.

Test Plan:
- RAM round trip: write 0xA5 to 0x00123, then read 0x00123 -> ram_we_o pulse with ram_a_o=0x00123; cpu_dat_o=0xA5 one cycle after the read request.
- UART output: write 'H' (0x48), then 0x00, then 'i' (0x69) to 0x30000, tx_ready_i held 0 -> FIFO holds 0x48,0x69 only; raise tx_ready_i -> tx_dat_o emits 0x48 then 0x69, tx_valid_o drops.
- Back-pressure: tx_ready_i=0, push 6 bytes -> io_buffer_full rises the cycle after the 6th; push 2 more -> FIFO full; 9th push -> dropped, ovf_o=1; one pop plus push in the same cycle -> count stays 8.
- Counter coherence: read 0x30004..0x30007 on consecutive cycles with counter at 0x000000FF at the first read -> returned bytes FF,00,00,00 even though the counter crosses 0x100 mid-sequence.
- Stop and RX: rx_valid_i=1, rx_dat_i=0x31, read 0x30000 -> rx_pop_o pulse, cpu_dat_o=0x31; write 0x30004 -> stop_o=1 and 0x00 appears on tx_dat_o.
- Stall/reset: hold rdy_in=0 for 5 cycles -> counter frozen, ram_we_o=0, cpu_dat_o held; assert rst_in mid-drain -> tx_valid_o, stop_o, ovf_o, io_buffer_full all 0 immediately.
